// File: rtl/sm_restore_serial.sv
// Bit-serial operand restore: a = b + r (Ne=0) or a = b - r (Ne=1), LSB first.
// Ports: clk, rst_n, start, b, r, Ne in; busy, done, a, cout out.
module sm_restore_serial #(
  parameter int x = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [x-1:0] b,
  input  logic [x-1:0] r,
  input  logic         Ne,
  output logic         busy,
  output logic         done,
  output logic [x-1:0] a,
  output logic         cout
);

  localparam int CW = $clog2(x) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [x-1:0]  b_q, r_q, s_q;
  logic          ne_q, c_q;
  logic [CW-1:0] cnt_q;
  logic          last, s_bit, c_nxt;
  logic          bx;

  assign last  = (cnt_q == CW'(x - 1));
  assign bx    = b_q[0] ^ r_q[0];
  assign s_bit = bx ^ c_q;

  // c is a carry when adding and a borrow when subtracting
  always_comb begin
    c_nxt = 1'b0;
    if (ne_q)
      c_nxt = (~b_q[0] & r_q[0]) | (c_q & ~bx);
    else
      c_nxt = (b_q[0] & r_q[0]) | (c_q & bx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q   <= '0;
      r_q   <= '0;
      s_q   <= '0;
      ne_q  <= 1'b0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      a     <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            b_q   <= b;
            r_q   <= r;
            ne_q  <= Ne;
            c_q   <= 1'b0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          s_q <= {s_bit, s_q[x-1:1]};
          b_q <= b_q >> 1;
          r_q <= r_q >> 1;
          c_q <= c_nxt;
          // wrap to 0 so cnt never exceeds x-1
          cnt_q <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            a    <= {s_bit, s_q[x-1:1]};
            cout <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_restore_serial.sv
// Directed bench for sm_restore_serial (x=4).
// Checks results, cout, done timing, start masking and async reset.
module tb_sm_restore_serial;

  localparam int X = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [X-1:0] b, r;
  logic         Ne;
  logic         busy, done;
  logic [X-1:0] a;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  sm_restore_serial #(.x(X)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .b    (b),
    .r    (r),
    .Ne   (Ne),
    .busy (busy),
    .done (done),
    .a    (a),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation; disturb=1 pulses start with other operands during RUN.
  task automatic run_op(input string tag, input logic [X-1:0] bb,
                        input logic [X-1:0] rr, input logic ne,
                        input logic [X-1:0] ea, input logic ec,
                        input bit disturb);
    logic [X-1:0] a_prev;
    logic         c_prev;
    @(negedge clk);
    a_prev = a;
    c_prev = cout;
    b = bb; r = rr; Ne = ne; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b = ~bb; r = ~rr; Ne = ~ne;
    check({tag, "_busy_acc"}, 8'(busy), 8'd1);
    for (int k = 1; k < X; k++) begin
      if (disturb && k == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_done_early"}, 8'(done), 8'd0);
      check({tag, "_a_stable"}, 8'(a), 8'(a_prev));
      check({tag, "_cout_stable"}, 8'(cout), 8'(c_prev));
    end
    @(posedge clk); #1;
    check({tag, "_done"}, 8'(done), 8'd1);
    check({tag, "_busy_done"}, 8'(busy), 8'd1);
    check({tag, "_a"}, 8'(a), 8'(ea));
    check({tag, "_cout"}, 8'(cout), 8'(ec));
    @(posedge clk); #1;
    check({tag, "_done_one"}, 8'(done), 8'd0);
    check({tag, "_busy_end"}, 8'(busy), 8'd0);
    check({tag, "_a_hold"}, 8'(a), 8'(ea));
  endtask

  initial begin
    logic [X-1:0] rv;
    logic         nv;
    rst_n = 1'b0;
    start = 1'b0;
    b = '0; r = '0; Ne = 1'b0;
    #1;
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_a", 8'(a), 8'd0);
    check("rst_cout", 8'(cout), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("t1", 4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0);
    run_op("t2a", 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0);
    run_op("t2b", 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);
    run_op("t3a", 4'b0011, 4'b0001, 1'b1, 4'b0010, 1'b0, 1'b0);
    run_op("t3b", 4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0);
    run_op("t4a", 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    run_op("t4b", 4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b1, 1'b0);
    run_op("t5", 4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1);
    run_op("t5b", 4'b1110, 4'b0011, 1'b1, 4'b1011, 1'b0, 1'b0);

    // reset two edges into RUN; previous a=1011 so clearing is visible
    @(negedge clk);
    b = 4'b0101; r = 4'b0101; Ne = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_busy", 8'(busy), 8'd0);
    check("t6_a", 8'(a), 8'd0);
    check("t6_cout", 8'(cout), 8'd0);
    for (int k = 0; k < X; k++) begin
      if (k == 2) rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6_nodone", 8'(done), 8'd0);
    end
    run_op("t6_after", 4'b0101, 4'b0101, 1'b0, 4'b1010, 1'b0, 1'b0);

    for (int a0 = 0; a0 < 16; a0++) begin
      for (int bi = 0; bi < 16; bi++) begin
        nv = (a0 < bi);
        rv = nv ? 4'(bi - a0) : 4'(a0 - bi);
        run_op("exh", 4'(bi), rv, nv, 4'(a0), 1'b0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
